// File: rtl/sram_ctrl.sv
// Controller for a 16-bit asynchronous SRAM behind a 32-bit MMIO bus: each word access is two halfword phases.
// Optional macro SRAM_WAIT_EN stretches every strobe by WAIT_CYC cycles; without it strobes are one cycle.
module sram_ctrl #(
    parameter int ADDR_W   = 18,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stb,
    output logic              ack,
    input  logic [31:0]       addr,
    input  logic [31:0]       dtw,
    output logic [31:0]       dtr,
    input  logic              rw,
    output logic [ADDR_W-1:0] sram_a,
    output logic [15:0]       sram_dq_o,
    input  logic [15:0]       sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    typedef enum logic [2:0] {
        IDLE, LO_SETUP, LO_STRB, HI_SETUP, HI_STRB, ACK
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-2:0] wa_q, wa_d;
    logic [31:0]       wd_q, wd_d;
    logic              rw_q, rw_d;
    logic [15:0]       rlo_q, rlo_d;
    logic [31:0]       dtr_q, dtr_d;

    logic              ack_q, ack_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [15:0]       dq_q, dq_d;

    logic              strb_last;
    logic              hi_phase;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:ADDR_W+1], addr[1:0]};

`ifdef SRAM_WAIT_EN
    localparam int CNT_W = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign strb_last = (cnt_q == '0);

    // Loaded on entry to a strobe state, counts down to zero on its last cycle.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d == LO_STRB || state_d == HI_STRB) && (state_q != state_d)) begin
            cnt_d = CNT_W'(WAIT_CYC);
        end else if ((state_q == LO_STRB || state_q == HI_STRB) && !strb_last) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_wait_cyc;
    assign unused_wait_cyc = (WAIT_CYC != 0);
    assign strb_last       = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        rw_d    = rw_q;
        rlo_d   = rlo_q;
        dtr_d   = dtr_q;
        case (state_q)
            IDLE: begin
                if (stb) begin
                    state_d = LO_SETUP;
                    wa_d    = addr[ADDR_W:2];
                    wd_d    = dtw;
                    rw_d    = rw;
                end
            end
            LO_SETUP: state_d = LO_STRB;
            LO_STRB: begin
                if (strb_last) begin
                    state_d = HI_SETUP;
                    if (!rw_q) rlo_d = sram_dq_i;
                end
            end
            HI_SETUP: state_d = HI_STRB;
            HI_STRB: begin
                if (strb_last) begin
                    state_d = ACK;
                    if (!rw_q) dtr_d = {sram_dq_i, rlo_q};
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pad-facing outputs are registered from the next state so they never glitch.
    always_comb begin
        ack_d    = 1'b0;
        ce_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        dq_oe_d  = 1'b0;
        a_d      = a_q;
        dq_d     = dq_q;
        hi_phase = (state_d == HI_SETUP) || (state_d == HI_STRB);
        case (state_d)
            LO_SETUP, LO_STRB, HI_SETUP, HI_STRB: begin
                ce_n_d = 1'b0;
                a_d    = {wa_d, hi_phase};
                if (rw_d) begin
                    dq_oe_d = 1'b1;
                    dq_d    = hi_phase ? wd_d[31:16] : wd_d[15:0];
                end
                if (state_d == LO_STRB || state_d == HI_STRB) begin
                    if (rw_d) we_n_d = 1'b0;
                    else      oe_n_d = 1'b0;
                end
            end
            ACK:     ack_d = 1'b1;
            default: ack_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            a_q     <= '0;
            dq_q    <= '0;
            dtr_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            dq_oe_q <= dq_oe_d;
            a_q     <= a_d;
            dq_q    <= dq_d;
            dtr_q   <= dtr_d;
        end
    end

    // Request latches and the low-half read buffer carry no reset; they are
    // only consumed after being loaded by an accepted access.
    always_ff @(posedge clk) begin
        wa_q  <= wa_d;
        wd_q  <= wd_d;
        rw_q  <= rw_d;
        rlo_q <= rlo_d;
    end

    assign ack        = ack_q;
    assign dtr        = dtr_q;
    assign sram_a     = a_q;
    assign sram_dq_o  = dq_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter ADDR_W, default 18: external SRAM halfword address width.
REQ-002 Parameter WAIT_CYC, default 1: extra strobe cycles per halfword phase; used only when SRAM_WAIT_EN is defined.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stb  input  1  bus request from the MMIO stage (its sstb).
REQ-006 ack  output  1  one-cycle completion pulse, returned as sack.
REQ-007 addr  input  32  byte address; bits [1:0] ignored; bits above ADDR_W+1 ignored.
REQ-008 dtw  input  32  write data.
REQ-009 dtr  output  32  read data, registered.
REQ-010 rw  input  1  1 = write, 0 = read.
REQ-011 sram_a  output  ADDR_W  halfword address to the external SRAM.
REQ-012 sram_dq_o  output  16  write data to the SRAM.
REQ-013 sram_dq_i  input  16  read data from the SRAM.
REQ-014 sram_dq_oe  output  1  pad output enable for the data bus.
REQ-015 sram_ce_n, sram_oe_n, sram_we_n  output  1 each  active-low chip, output and write enables.

Function
REQ-016 Each 32-bit access is split into two halfword phases: LO (sram_a = {addr[ADDR_W:2],0}, bits 15:0) and then HI (sram_a = {addr[ADDR_W:2],1}, bits 31:16).
REQ-017 FSM states: IDLE, LO_SETUP, LO_STRB, HI_SETUP, HI_STRB, ACK.
REQ-018 IDLE: stb=1 latches addr, dtw and rw on that edge and moves to LO_SETUP; stb=0 stays in IDLE.
REQ-019 SETUP states last 1 cycle: sram_ce_n=0, address valid, sram_oe_n=1, sram_we_n=1; for writes sram_dq_oe=1 with the phase halfword on sram_dq_o.
REQ-020 STRB states last 1 cycle plus WAIT_CYC cycles when enabled; a down-counter tracks the cycles: sram_ce_n=0, with sram_we_n=0 for writes or sram_oe_n=0 for reads; address and data stay stable.
REQ-021 Reads capture sram_dq_i on the last STRB cycle of each phase into the matching half of an internal buffer; dtr updates only on entry to ACK.
REQ-022 ACK: ack=1 for exactly 1 cycle with all SRAM strobes inactive, then IDLE.
REQ-023 Latency: ack is high 5 cycles after the accepting edge (5+2*WAIT_CYC with SRAM_WAIT_EN); no pipelining, one transaction outstanding.
REQ-024 Latched request values are used throughout, so changes to addr, dtw, rw or stb after acceptance have no effect; a dropped stb does not abort the access.
REQ-025 stb still high in IDLE after ACK starts a new access, so the master shall drop stb on ack.
REQ-026 sram_dq_oe is 0 in every cycle of a read and in IDLE and ACK.
REQ-027 dtr holds its last read value across writes and idle time.

Reset
REQ-028 Reset has priority in any state: on the same edge the FSM goes to IDLE, ack=0, sram_ce_n=sram_oe_n=sram_we_n=1, sram_dq_oe=0, dtr=0, sram_a=0, sram_dq_o=0 and the counter is cleared.
REQ-029 Reset during an access abandons it with no ack; a half-written word is permitted.

Configuration
REQ-030 Macro SRAM_WAIT_EN: when defined, STRB states last 1+WAIT_CYC cycles; when undefined, STRB states last exactly 1 cycle, WAIT_CYC is ignored and the counter is not built.

Verification
REQ-031 Write addr=0x0000_0104, dtw=0xDEAD_BEEF, macro off -> sram_a=0x82 carries 0xBEEF, then 0x83 carries 0xDEAD, sram_we_n low 1 cycle each, ack 5 cycles after acceptance.
REQ-032 Read the same address with the SRAM model returning the stored data -> dtr=0xDEAD_BEEF with ack; sram_dq_oe=0 throughout.
REQ-033 SRAM_WAIT_EN defined, WAIT_CYC=2 -> each strobe lasts 3 cycles and ack arrives 9 cycles after acceptance.
REQ-034 Reset asserted in HI_STRB of a write -> next cycle all strobes are inactive, ack=0, FSM in IDLE; a following read completes normally.
REQ-035 stb held high through ack -> a second access starts the cycle after ACK; stb dropped 1 cycle after acceptance -> the access still completes with one ack.
REQ-036 addr=0xFFFF_FFFC with ADDR_W=18 -> sram_a=0x3FFFE then 0x3FFFF, and upper address bits are ignored.
